ram_byte_master: RTL and testbench

//  Initiator-side sequencer for the byte-wide, 4096-entry data RAM. Accepts one

---
 rtl/ram_byte_master.sv | 175 +++++++++++++++++
 tb/tb_ram_byte_master.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/ram_byte_master.sv
// Load/store sequencer for a byte-wide RAM: walks the bytes of one access in
// little-endian order, one per cycle, and returns a single-cycle response.
module ram_byte_master #(
  parameter int unsigned ADDR_WIDTH  = 12,
  parameter int unsigned ALIGN_CHECK = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  output logic                  resp_err,
  output logic [31:0]           resp_rdata,
  output logic                  ram_r_wn,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic [7:0]            ram_wdata,
  input  logic [7:0]            ram_rdata
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    RESP   = 2'b10
  } state_t;

  state_t                state_r;
  state_t                state_next_s;
  logic                  we_r;
  logic                  uns_r;
  logic [1:0]            size_r;
  logic [1:0]            cnt_r;
  logic [ADDR_WIDTH-1:0] addr_r;
  logic [31:0]           wdata_r;
  logic [31:0]           acc_r;
  logic                  resp_valid_r;
  logic                  resp_err_r;
  logic [31:0]           resp_rdata_r;
  logic                  req_err_s;
  logic [1:0]            last_idx_s;
  logic                  last_s;
  logic [31:0]           acc_next_s;

  function automatic logic [31:0] extend_load(input logic [31:0] acc,
                                              input logic [1:0]  size,
                                              input logic        uns);
    case (size)
      2'b00:   return {{24{~uns & acc[7]}}, acc[7:0]};
      2'b01:   return {{16{~uns & acc[15]}}, acc[15:0]};
      default: return acc;
    endcase
  endfunction

  // Illegal size or (when checking) misalignment is rejected before any RAM access
  always_comb begin
    req_err_s = 1'b0;
    if (req_size == 2'b11) begin
      req_err_s = 1'b1;
    end else if (ALIGN_CHECK != 0) begin
      if (req_size == 2'b01) begin
        req_err_s = req_addr[0];
      end else if (req_size == 2'b10) begin
        req_err_s = (req_addr[1:0] != 2'b00);
      end else begin
        req_err_s = 1'b0;
      end
    end else begin
      req_err_s = 1'b0;
    end
  end

  // Last byte index of the access and the accumulator with this cycle's byte merged in
  always_comb begin
    last_idx_s = 2'd3;
    case (size_r)
      2'b00:   last_idx_s = 2'd0;
      2'b01:   last_idx_s = 2'd1;
      default: last_idx_s = 2'd3;
    endcase
    last_s     = (cnt_r == last_idx_s);
    acc_next_s = acc_r | ({24'd0, ram_rdata} << {cnt_r, 3'b000});
  end

  // Next-state logic
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (req_valid) begin
          state_next_s = req_err_s ? RESP : ACCESS;
        end else begin
          state_next_s = IDLE;
        end
      end
      ACCESS: begin
        if (last_s) begin
          state_next_s = RESP;
        end else begin
          state_next_s = ACCESS;
        end
      end
      RESP:    state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // State, request capture, byte walk and registered response
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      we_r         <= 1'b0;
      uns_r        <= 1'b0;
      size_r       <= 2'b00;
      cnt_r        <= 2'd0;
      addr_r       <= '0;
      wdata_r      <= 32'd0;
      acc_r        <= 32'd0;
      resp_valid_r <= 1'b0;
      resp_err_r   <= 1'b0;
      resp_rdata_r <= 32'd0;
    end else begin
      state_r      <= state_next_s;
      resp_valid_r <= 1'b0;
      resp_err_r   <= 1'b0;
      resp_rdata_r <= 32'd0;
      case (state_r)
        IDLE: begin
          if (req_valid) begin
            we_r    <= req_we;
            size_r  <= req_size;
            uns_r   <= req_unsigned;
            wdata_r <= req_wdata;
            cnt_r   <= 2'd0;
            acc_r   <= 32'd0;
            if (req_err_s) begin
              resp_valid_r <= 1'b1;
              resp_err_r   <= 1'b1;
            end else begin
              addr_r <= req_addr;
            end
          end
        end
        ACCESS: begin
          cnt_r   <= cnt_r + 2'd1;
          wdata_r <= {8'd0, wdata_r[31:8]};
          if (!we_r) begin
            acc_r <= acc_next_s;
          end
          // Address stops on the last byte so it holds outside ACCESS
          if (last_s) begin
            resp_valid_r <= 1'b1;
            resp_rdata_r <= we_r ? 32'd0 : extend_load(acc_next_s, size_r, uns_r);
          end else begin
            addr_r <= addr_r + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
          end
        end
        default: ;
      endcase
    end
  end

  // rst_n gates the write strobe so a reset during a store cycle blocks that byte
  assign ram_r_wn    = ~(rst_n & we_r & (state_r == ACCESS));
  assign ram_wdata   = ram_r_wn ? 8'd0 : wdata_r[7:0];
  assign ram_address = addr_r;
  assign req_ready   = (state_r == IDLE);
  assign resp_valid  = resp_valid_r;
  assign resp_err    = resp_err_r;
  assign resp_rdata  = resp_rdata_r;

endmodule

// File: tb/tb_ram_byte_master.sv
// Randomized bench for ram_byte_master: two instances (alignment checked / not
// checked), each on its own byte RAM, compared against a byte-array reference model.
module tb_ram_byte_master;
  localparam int AW    = 12;
  localparam int DEPTH = 4096;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid    [2];
  logic          req_ready    [2];
  logic          req_we       [2];
  logic [1:0]    req_size     [2];
  logic          req_unsigned [2];
  logic [AW-1:0] req_addr     [2];
  logic [31:0]   req_wdata    [2];
  logic          resp_valid   [2];
  logic          resp_err     [2];
  logic [31:0]   resp_rdata   [2];
  logic          ram_r_wn     [2];
  logic [AW-1:0] ram_address  [2];
  logic [7:0]    ram_wdata    [2];
  logic [7:0]    ram_rdata    [2];

  logic [7:0] ref_mem [2][DEPTH];
  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic [7:0] mem [DEPTH];

    ram_byte_master #(.ADDR_WIDTH(AW), .ALIGN_CHECK((g == 0) ? 1 : 0)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid[g]), .req_ready(req_ready[g]), .req_we(req_we[g]),
      .req_size(req_size[g]), .req_unsigned(req_unsigned[g]), .req_addr(req_addr[g]),
      .req_wdata(req_wdata[g]), .resp_valid(resp_valid[g]), .resp_err(resp_err[g]),
      .resp_rdata(resp_rdata[g]), .ram_r_wn(ram_r_wn[g]), .ram_address(ram_address[g]),
      .ram_wdata(ram_wdata[g]), .ram_rdata(ram_rdata[g])
    );

    initial for (int i = 0; i < DEPTH; i++) mem[i] = 8'd0;
    assign ram_rdata[g] = mem[ram_address[g]];
    always @(posedge clk) if (!ram_r_wn[g]) mem[ram_address[g]] <= ram_wdata[g];
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [7:0] peek(input int which, input int a);
    if (which == 0) return g_dut[0].mem[a];
    else return g_dut[1].mem[a];
  endfunction

  // Reference: bytes at (addr+i) mod DEPTH, little-endian, signed value arithmetic
  task automatic model(input int which, input bit we, input int size, input bit uns,
                       input int addr, input logic [31:0] wdata,
                       output bit err, output int n, output logic [31:0] rdata);
    longint v = 0;
    err = (size == 3) ||
          (which == 0 && ((size == 1 && addr % 2 != 0) || (size == 2 && addr % 4 != 0)));
    n = err ? 0 : (size == 0 ? 1 : (size == 1 ? 2 : 4));
    for (int i = 0; i < n; i++) begin
      int a = (addr + i) % DEPTH;
      if (we) ref_mem[which][a] = 8'((wdata >> (8 * i)) & 32'hFF);
      else v += longint'(ref_mem[which][a]) << (8 * i);
    end
    if (!err && !we && n < 4 && !uns && v >= (longint'(1) << (8 * n - 1)))
      v = v - (longint'(1) << (8 * n));
    rdata = (err || we) ? 32'd0 : v[31:0];
  endtask

  task automatic check_reset_outputs(input int which);
    check_eq("rst_ready", 32'(req_ready[which]), 32'd1);
    check_eq("rst_rvalid", 32'(resp_valid[which]), 32'd0);
    check_eq("rst_err", 32'(resp_err[which]), 32'd0);
    check_eq("rst_rdata", resp_rdata[which], 32'd0);
    check_eq("rst_rwn", 32'(ram_r_wn[which]), 32'd1);
    check_eq("rst_addr", 32'(ram_address[which]), 32'd0);
    check_eq("rst_wdata", 32'(ram_wdata[which]), 32'd0);
  endtask

  task automatic txn(input int which, input bit we, input int size, input bit uns,
                     input int addr, input logic [31:0] wdata, output logic [31:0] got);
    bit err;
    int n;
    int cyc;
    logic [31:0] exp;
    model(which, we, size, uns, addr, wdata, err, n, exp);
    check_eq("ready", 32'(req_ready[which]), 32'd1);
    req_valid[which]    = 1'b1;
    req_we[which]       = we;
    req_size[which]     = 2'(size);
    req_unsigned[which] = uns;
    req_addr[which]     = AW'(addr);
    req_wdata[which]    = wdata;
    @(posedge clk); #1;
    cyc = 1;
    while (resp_valid[which] !== 1'b1 && cyc < 12) begin
      // busy-time requests must be ignored
      req_valid[which] = 1'($urandom);
      req_we[which]    = 1'($urandom);
      req_size[which]  = 2'($urandom);
      req_addr[which]  = AW'($urandom);
      req_wdata[which] = $urandom;
      if (cyc <= n) begin
        check_eq("acc_addr", 32'(ram_address[which]), 32'((addr + cyc - 1) % DEPTH));
        check_eq("acc_rwn", 32'(ram_r_wn[which]), 32'(!we));
        if (we) check_eq("acc_wdata", 32'(ram_wdata[which]), (wdata >> (8 * (cyc - 1))) & 32'hFF);
        check_eq("acc_ready", 32'(req_ready[which]), 32'd0);
      end
      @(posedge clk); #1;
      cyc++;
    end
    req_valid[which] = 1'b0;
    check_eq("latency", 32'(cyc), 32'(n + 1));
    check_eq("resp_err", 32'(resp_err[which]), 32'(err));
    check_eq("resp_rdata", resp_rdata[which], exp);
    check_eq("resp_rwn", 32'(ram_r_wn[which]), 32'd1);
    check_eq("resp_ready", 32'(req_ready[which]), 32'd0);
    got = resp_rdata[which];
    @(posedge clk); #1;
    check_eq("pulse", 32'(resp_valid[which]), 32'd0);
    for (int i = 0; i < 5; i++) begin
      int a = (addr + i) % DEPTH;
      check_eq("ram", 32'(peek(which, a)), 32'(ref_mem[which][a]));
    end
  endtask

  initial begin
    logic [31:0] got;
    for (int w = 0; w < 2; w++) begin
      for (int i = 0; i < DEPTH; i++) ref_mem[w][i] = 8'd0;
      req_valid[w] = 1'b0; req_we[w] = 1'b0; req_size[w] = 2'b00;
      req_unsigned[w] = 1'b0; req_addr[w] = '0; req_wdata[w] = 32'd0;
    end
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs(0);
    check_reset_outputs(1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed cases, alignment checked
    txn(0, 1, 2, 0, 'h010, 32'h11223344, got);
    txn(0, 0, 2, 0, 'h010, 32'd0, got);
    check_eq("lw", got, 32'h11223344);
    check_eq("b10", 32'(peek(0, 'h10)), 32'h44);
    check_eq("b13", 32'(peek(0, 'h13)), 32'h11);
    txn(0, 0, 0, 0, 'h013, 32'd0, got);  check_eq("lb13", got, 32'h00000011);
    txn(0, 1, 0, 0, 'h020, 32'h80, got);
    txn(0, 0, 0, 0, 'h020, 32'd0, got);  check_eq("lb20", got, 32'hFFFFFF80);
    txn(0, 0, 0, 1, 'h020, 32'd0, got);  check_eq("lbu20", got, 32'h00000080);
    txn(0, 1, 1, 0, 'h102, 32'h1234BEEF, got);
    txn(0, 0, 1, 0, 'h102, 32'd0, got);  check_eq("lh", got, 32'hFFFFBEEF);
    txn(0, 0, 1, 1, 'h102, 32'd0, got);  check_eq("lhu", got, 32'h0000BEEF);
    check_eq("b104", 32'(peek(0, 'h104)), 32'h00);
    txn(0, 0, 2, 0, 'h001, 32'd0, got);  check_eq("lw_mis", got, 32'd0);
    txn(0, 1, 3, 0, 'h030, 32'hDEADBEEF, got);
    check_eq("b30", 32'(peek(0, 'h30)), 32'h00);

    // Wraparound without alignment check
    txn(1, 1, 2, 0, 'hFFE, 32'hAABBCCDD, got);
    check_eq("bffe", 32'(peek(1, 'hFFE)), 32'hDD);
    check_eq("bfff", 32'(peek(1, 'hFFF)), 32'hCC);
    check_eq("b000", 32'(peek(1, 'h000)), 32'hBB);
    check_eq("b001", 32'(peek(1, 'h001)), 32'hAA);
    txn(1, 0, 2, 0, 'hFFE, 32'd0, got);  check_eq("lw_wrap", got, 32'hAABBCCDD);

    // Reset asserted during the second byte of a store
    req_valid[1] = 1'b1; req_we[1] = 1'b1; req_size[1] = 2'b10;
    req_unsigned[1] = 1'b0; req_addr[1] = 12'h200; req_wdata[1] = 32'h55667788;
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check_reset_outputs(1);
    rst_n = 1'b1;
    ref_mem[1]['h200] = 8'h88;
    for (int i = 0; i < 3; i++) begin
      check_eq("abort_norsp", 32'(resp_valid[1]), 32'd0);
      @(posedge clk); #1;
    end
    check_eq("abort_b0", 32'(peek(1, 'h200)), 32'h88);
    check_eq("abort_b1", 32'(peek(1, 'h201)), 32'h00);
    check_eq("abort_b2", 32'(peek(1, 'h202)), 32'h00);

    // Random traffic in two small windows so loads revisit stored bytes
    for (int k = 0; k < 200; k++) begin
      int which = int'($urandom_range(1, 0));
      int size  = ($urandom_range(7, 0) == 0) ? 3 : int'($urandom_range(2, 0));
      int addr  = ($urandom_range(1, 0) == 1) ? int'($urandom_range(63, 0))
                                              : int'($urandom_range(DEPTH - 1, DEPTH - 8));
      txn(which, 1'($urandom), size, 1'($urandom), addr, $urandom, got);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
